// File: rtl/lht_pkg.sv
// ============================================================================
// Module   : lht_pkg
// Purpose  : Shared types and defaults for the local branch-history table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lht_pkg;

  localparam int LHT_DEF_ENTRIES = 16;
  localparam int LHT_DEF_HIST_W  = 62;
  // Upper bound on the index width carried in lht_upd_t
  localparam int LHT_IDX_MAX_W   = 16;

  typedef enum logic [0:0] {
    LHT_INIT = 1'b0,
    LHT_RUN  = 1'b1
  } lht_state_e;

  typedef struct packed {
    logic [LHT_IDX_MAX_W-1:0] idx;
    logic                     taken;
  } lht_upd_t;

endpackage

`default_nettype wire

// File: rtl/lht_storage.sv
// ============================================================================
// Module   : lht_storage
// Purpose  : Un-reset history array, one combinational read port and one
//            synchronous write port; drop-in point for an SRAM macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lht_storage #(
  parameter int NUM_ENTRIES = 16,
  parameter int HIST_W      = 62,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [HIST_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [HIST_W-1:0] rdata
);

  logic [HIST_W-1:0] r_mem [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/local_hist_unit.sv
// ============================================================================
// Module   : local_hist_unit
// Purpose  : Local branch-history table with fetch lookup and commit update
//            ports plus a post-reset/clear zeroing sweep.
//            Macro LHT_BYPASS_EN: same-cycle collision returns write-first data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module local_hist_unit
  import lht_pkg::*;
#(
  parameter  int NUM_ENTRIES = LHT_DEF_ENTRIES,
  parameter  int HIST_W      = LHT_DEF_HIST_W,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  output logic              ready,
  input  logic              lkup_valid,
  input  logic [IDX_W-1:0]  lkup_idx,
  output logic              lkup_rvalid,
  output logic [HIST_W-1:0] lkup_hist,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken
);

`ifdef LHT_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  lht_state_e        r_state;
  lht_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic              w_last;
  logic              w_lkup_acc;
  logic              w_upd_acc;
  logic              w_hit;
  lht_upd_t          w_upd;
  logic [HIST_W-1:0] w_upd_shift;
  logic [HIST_W-1:0] w_lkup_data;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr;
  logic [HIST_W-1:0] w_wdata;
  logic [IDX_W-1:0]  w_raddr [2];
  logic [HIST_W-1:0] w_rd    [2];
  logic              r_lkup_rvalid;
  logic [HIST_W-1:0] r_lkup_hist;

  assign ready      = (r_state == LHT_RUN);
  assign w_last     = (r_ptr == IDX_W'(NUM_ENTRIES - 1));
  assign w_lkup_acc = lkup_valid & ready;
  assign w_upd_acc  = upd_valid & ready;

  assign w_upd.idx   = LHT_IDX_MAX_W'(upd_idx);
  assign w_upd.taken = upd_taken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LHT_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      LHT_INIT: begin
        if (clear) begin
          w_ptr_nxt = '0;
        end else if (w_last) begin
          w_state_nxt = LHT_RUN;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + IDX_W'(1);
        end
      end
      LHT_RUN: begin
        if (clear) begin
          w_state_nxt = LHT_INIT;
          w_ptr_nxt   = '0;
        end
      end
    endcase
  end

  // Bank 0 serves fetch lookups, bank 1 supplies the old history for the shift
  assign w_raddr[0] = lkup_idx;
  assign w_raddr[1] = w_upd.idx[IDX_W-1:0];

  assign w_upd_shift = {w_rd[1][HIST_W-2:0], w_upd.taken};

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_upd.idx[IDX_W-1:0];
    w_wdata = w_upd_shift;
    if (r_state == LHT_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wdata = '0;
    end else if (w_upd_acc) begin
      w_we = 1'b1;
    end
  end

  generate
    for (genvar b = 0; b < 2; b++) begin : g_bank
      lht_storage #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .HIST_W      (HIST_W),
        .IDX_W       (IDX_W)
      ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_raddr[b]),
        .rdata (w_rd[b])
      );
    end
  endgenerate

  assign w_hit       = w_upd_acc && (w_upd.idx == LHT_IDX_MAX_W'(lkup_idx));
  assign w_lkup_data = (c_bypass && w_hit) ? w_upd_shift : w_rd[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lkup_rvalid <= 1'b0;
      r_lkup_hist   <= '0;
    end else begin
      r_lkup_rvalid <= w_lkup_acc;
      if (w_lkup_acc) begin
        r_lkup_hist <= w_lkup_data;
      end
    end
  end

  assign lkup_rvalid = r_lkup_rvalid;
  assign lkup_hist   = r_lkup_hist;

endmodule

`default_nettype wire

// File: tb/tb_local_hist_unit.sv
// ============================================================================
// Module   : tb_local_hist_unit
// Purpose  : Randomised scoreboard bench for local_hist_unit against an
//            array-based history model (honours LHT_BYPASS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_local_hist_unit;

  localparam int c_n  = 16;
  localparam int c_w  = 62;
  localparam int c_iw = 4;

  logic           clk        = 1'b0;
  logic           rst_n      = 1'b1;
  logic           clear      = 1'b0;
  logic           lkup_valid = 1'b0;
  logic [c_iw-1:0] lkup_idx  = '0;
  logic           upd_valid  = 1'b0;
  logic [c_iw-1:0] upd_idx   = '0;
  logic           upd_taken  = 1'b0;
  logic           ready;
  logic           lkup_rvalid;
  logic [c_w-1:0] lkup_hist;

  always #5 clk = ~clk;

  local_hist_unit #(
    .NUM_ENTRIES (c_n),
    .HIST_W      (c_w)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .ready       (ready),
    .lkup_valid  (lkup_valid),
    .lkup_idx    (lkup_idx),
    .lkup_rvalid (lkup_rvalid),
    .lkup_hist   (lkup_hist),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken)
  );

  typedef struct {
    int             cyc;
    logic [c_w-1:0] v;
  } exp_t;

  exp_t           q[$];
  logic [c_w-1:0] m [c_n];
  logic [c_w-1:0] last_v = '0;
  int             init_left = c_n;
  int             cyc = 0;
  int             n_chk = 0;
  int             n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every lookup response must land exactly one cycle after its request
  always @(negedge clk) begin
    if (rst_n) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("lkup_rvalid", 64'(lkup_rvalid), 64'd1);
        chk("lkup_hist", 64'(lkup_hist), 64'(q[0].v));
        last_v = q[0].v;
        void'(q.pop_front());
      end else begin
        chk("lkup_rvalid_idle", 64'(lkup_rvalid), 64'd0);
        chk("lkup_hist_hold", 64'(lkup_hist), 64'(last_v));
      end
    end
  end

  task automatic step(input bit lv, input int li, input bit uv, input int ui,
                      input bit ut, input bit cl);
    exp_t e;
    bit   rdy;
    lkup_valid = lv;
    lkup_idx   = c_iw'(li);
    upd_valid  = uv;
    upd_idx    = c_iw'(ui);
    upd_taken  = ut;
    clear      = cl;
    rdy = (init_left == 0);
    chk("ready", 64'(ready), 64'(rdy));
    if (lv && rdy) begin
      e.v = m[li];
`ifdef LHT_BYPASS_EN
      if (uv && ui == li) e.v = {m[li][c_w-2:0], ut};
`endif
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    if (uv && rdy) m[ui] = {m[ui][c_w-2:0], ut};
    if (cl) begin
      foreach (m[i]) m[i] = '0;
      init_left = c_n;
    end else if (init_left > 0) begin
      init_left--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Requests during the sweep must all be ignored, so drive them freely
  task automatic wait_sweep();
    while (init_left > 0)
      step(1'($urandom), int'($urandom % c_n), 1'b1, int'($urandom % c_n), 1'($urandom), 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    lkup_valid = 1'b0;
    upd_valid  = 1'b0;
    clear      = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rvalid", 64'(lkup_rvalid), 64'd0);
    chk("rst_hist", 64'(lkup_hist), 64'd0);
    q.delete();
    last_v = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (m[i]) m[i] = '0;
    init_left = c_n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    wait_sweep();
    for (int i = 0; i < c_n; i++) step(1'b1, i, 1'b0, 0, 1'b0, 1'b0);

    step(1'b0, 0, 1'b1, 3, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 3, 1'b1, 1'b0);
    step(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 4, 1'b0, 0, 1'b0, 1'b0);

    repeat (62) step(1'b0, 0, 1'b1, 7, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 7, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 0, 1'b0, 1'b0);

    step(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
    step(1'b1, 5, 1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);

    repeat (3) step(1'b0, 0, 1'b1, 9, 1'b1, 1'b0);
    step(1'b1, 9, 1'b0, 0, 1'b0, 1'b1);
    wait_sweep();
    step(1'b1, 9, 1'b0, 0, 1'b0, 1'b0);
    idle();

    for (int k = 0; k < 1500; k++) begin
      int li;
      int ui;
      li = int'($urandom % c_n);
      ui = ($urandom % 4 == 0) ? li : int'($urandom % c_n);
      step(1'($urandom), li, ($urandom % 4 != 0), ui, 1'($urandom),
           ($urandom % 150 == 0));
    end
    wait_sweep();
    idle();

    step(1'b0, 0, 1'b1, 2, 1'b1, 1'b0);
    step(1'b1, 2, 1'b0, 0, 1'b0, 1'b1);
    repeat (8) step(1'b1, 2, 1'b1, 2, 1'b1, 1'b0);
    do_reset();
    wait_sweep();
    for (int i = 0; i < c_n; i++) step(1'b1, i, 1'b0, 0, 1'b0, 1'b0);
    idle();
    idle();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
